mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  Pipeline MEM stage, directly downstream of execute; consumes EX/MEM register outputs.
//  Drives data-memory requests with byte enables and aligns/extends load data.
//  Supplies an LFSR value for random instructions and registers the final write-back
//  value into MEM/WB. Generates stall_mem while a memory access is outstanding.
// PARAMETERS
//  LFSR_SEED  32'hACE1_2468  LFSR reset/reload value; must be non-zero
//  LFSR_TAPS  32'h8020_0003  Galois feedback mask
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   synchronous reset, active-low
//  next_pc_mem      in   32  PC+4 of instruction in MEM
//  alu_result_mem   in   32  address (ld/st) or ALU result
//  write_data_mem   in   32  store data, right-justified
//  wb_sel_mem       in   2   00 ALU, 01 load, 10 next_pc, 11 random
//  read_width_mem   in   2   00 byte, 01 half, 10 word (11 treated as word)
//  read_unsigned_mem in  1   1 = zero-extend loads
//  rd_en_mem        in   1   load
//  mem_wrt_en_mem   in   1   store
//  reg_wrt_en_mem   in   1   register write enable
//  wrt_dst_mem      in   5   destination register
//  random_mem       in   1   random instruction (forces wb_sel 11)
//  rdi_mem          in   1   passed through to WB
//  dmem_req         out  1   memory request
//  dmem_we          out  1   1 = write
//  dmem_addr        out  32  {alu_result_mem[31:2],2'b00}
//  dmem_wdata       out  32  lane-replicated store data
//  dmem_be          out  4   byte enables
//  dmem_ack         in   1   access complete; rdata valid this cycle
//  dmem_rdata       in   32  read word
//  stall_mem        out  1   freeze EX/MEM and upstream
//  wb_data_wb       out  32  final write-back value
//  wrt_dst_wb       out  5   destination register
//  reg_wrt_en_wb    out  1   register write enable
//  rdi_wb           out  1   registered rdi_mem
//  misalign_wb      out  1   one-cycle flag: suppressed misaligned access
// BEHAVIOUR
//  - Reset: FSM=IDLE, lfsr=LFSR_SEED. All *_wb outputs are 0. dmem_req=0 and stall_mem=0.
//  - Access = (rd_en_mem|mem_wrt_en_mem) & aligned.
//    Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//  - FSM IDLE: on access, dmem_req=1 and stall_mem=1, go to WAIT; dmem_ack ignored in IDLE.
//  - FSM WAIT: dmem_req held and stall_mem=1 until dmem_ack. In the ack cycle, stall_mem=0,
//    MEM/WB captures the result, and the FSM goes to IDLE. Minimum access is 2 cycles.
//  - dmem_we/addr/wdata/be are combinational from EX/MEM inputs and are stable while stalled.
//  - Store byte enables: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
//    dmem_wdata is {4{b}}, {2{h}} or the full word.
//  - Load: the byte/half is selected by a[1:0] from dmem_rdata (ack cycle), then sign- or
//    zero-extended per read_unsigned_mem.
//  - Misaligned load/store: no request and no stall.
//    MEM/WB gets reg_wrt_en_wb=0 and misalign_wb=1.
//  - wb_data select: ALU→alu_result_mem; load→extended data; next_pc→next_pc_mem;
//    random (wb_sel 11 or random_mem)→current lfsr.
//  - MEM/WB register: loads whenever stall_mem=0. While stalled it loads a bubble
//    (reg_wrt_en_wb=0, misalign_wb=0); other fields hold.
//  - LFSR: advances every non-reset cycle. If its state is 0, it reloads LFSR_SEED next cycle.
//  - Reset mid-access: the FSM returns to IDLE, dmem_req drops next cycle, and a late
//    dmem_ack is ignored.
//  - Non-memory instruction: single-cycle passthrough, stall_mem=0.
// TESTING
//  - ALU op, alu_result=32'h1234, wb_sel=00 → next cycle wb_data_wb=32'h1234,
//    reg_wrt_en_wb=1, stall_mem=0.
//  - lb at addr 0x103, rdata=0x80FF_0000, ack after 3 cycles → stall_mem high 3 cycles,
//    then wb_data_wb=0xFFFF_FF80. Same with lbu → 0x0000_0080.
//  - sh at 0x202, data 0xBEEF → dmem_be=1100, dmem_wdata=0xBEEF_BEEF,
//    dmem_addr=0x200, dmem_we=1.
//  - lw at 0x101 → no dmem_req, stall_mem=0, misalign_wb=1, reg_wrt_en_wb=0.
//  - rst_n low during WAIT, ack the cycle after → FSM IDLE, all *_wb=0, no capture.
//  - Two back-to-back random ops after reset → wb_data_wb values differ.
//    The first equals LFSR_SEED stepped per cycle count.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage. Issues data-memory requests with byte enables,
// stalls upstream until the access completes, aligns and extends load data, supplies
// an LFSR value for random instructions and registers the write-back value into MEM/WB.
module mem_stage #(
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468,
  parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_mem,
  input  logic [1:0]  wb_sel_mem,
  input  logic [1:0]  read_width_mem,
  input  logic        read_unsigned_mem,
  input  logic        rd_en_mem,
  input  logic        mem_wrt_en_mem,
  input  logic        reg_wrt_en_mem,
  input  logic [4:0]  wrt_dst_mem,
  input  logic        random_mem,
  input  logic        rdi_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_mem,
  output logic [31:0] wb_data_wb,
  output logic [4:0]  wrt_dst_wb,
  output logic        reg_wrt_en_wb,
  output logic        rdi_wb,
  output logic        misalign_wb
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;

  localparam logic [1:0] SEL_ALU    = 2'b00;
  localparam logic [1:0] SEL_LOAD   = 2'b01;
  localparam logic [1:0] SEL_NPC    = 2'b10;
  localparam logic [1:0] SEL_RANDOM = 2'b11;

  state_t      state;
  state_t      state_next;
  logic [31:0] lfsr;
  logic [1:0]  offset;
  logic        is_mem;
  logic        bad_align;
  logic        misalign;
  logic        access;
  logic [31:0] rdata_shifted;
  logic [31:0] load_data;
  logic [1:0]  wb_sel;
  logic [31:0] wb_data;

  assign offset    = alu_result_mem[1:0];
  assign is_mem    = rd_en_mem | mem_wrt_en_mem;
  assign misalign  = is_mem & bad_align;
  assign access    = is_mem & ~bad_align;
  assign dmem_addr = {alu_result_mem[31:2], 2'b00};
  assign dmem_we   = mem_wrt_en_mem;

  // Alignment check: halves need an even address, words (and width 11) a word address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    bad_align = 1'b0;
    case (read_width_mem)
      WIDTH_BYTE: bad_align = 1'b0;
      WIDTH_HALF: bad_align = offset[0];
      default:    bad_align = (offset != 2'b00);
    endcase
  end

  // Store lane steering: replicate data across lanes, enable only the addressed bytes.
  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = write_data_mem;
    case (read_width_mem)
      WIDTH_BYTE: begin
        dmem_be    = 4'b0001 << offset;
        dmem_wdata = {4{write_data_mem[7:0]}};
      end
      WIDTH_HALF: begin
        dmem_be    = 4'b0011 << offset;
        dmem_wdata = {2{write_data_mem[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = write_data_mem;
      end
    endcase
  end

  // Load alignment: shift the addressed byte/half down, then sign- or zero-extend.
  assign rdata_shifted = dmem_rdata >> {offset, 3'b000};

  always_comb begin
    load_data = dmem_rdata;
    case (read_width_mem)
      WIDTH_BYTE: load_data = {{24{~read_unsigned_mem & rdata_shifted[7]}},
                               rdata_shifted[7:0]};
      WIDTH_HALF: load_data = {{16{~read_unsigned_mem & rdata_shifted[15]}},
                               rdata_shifted[15:0]};
      default:    load_data = dmem_rdata;
    endcase
  end

  // Write-back source select; a random instruction overrides wb_sel.
  assign wb_sel = random_mem ? SEL_RANDOM : wb_sel_mem;

  always_comb begin
    wb_data = alu_result_mem;
    case (wb_sel)
      SEL_ALU:    wb_data = alu_result_mem;
      SEL_LOAD:   wb_data = load_data;
      SEL_NPC:    wb_data = next_pc_mem;
      SEL_RANDOM: wb_data = lfsr;
      default:    wb_data = alu_result_mem;
    endcase
  end

  // Access FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Access FSM next state and outputs. An ack seen in IDLE is never a completion, so a
  // late ack after a reset cannot be mistaken for one. In WAIT the request stays up
  // through a reset cycle and drops once the state register has returned to IDLE.
  always_comb begin
    state_next = state;
    dmem_req   = 1'b0;
    stall_mem  = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && rst_n) begin
          dmem_req   = 1'b1;
          stall_mem  = 1'b1;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_next = S_IDLE;
        else          stall_mem  = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // MEM/WB register: captures whenever not stalled, otherwise inserts a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_data_wb    <= '0;
      wrt_dst_wb    <= '0;
      reg_wrt_en_wb <= 1'b0;
      rdi_wb        <= 1'b0;
      misalign_wb   <= 1'b0;
    end else if (!stall_mem) begin
      wb_data_wb    <= wb_data;
      wrt_dst_wb    <= wrt_dst_mem;
      reg_wrt_en_wb <= reg_wrt_en_mem & ~misalign;
      rdi_wb        <= rdi_mem;
      misalign_wb   <= misalign;
    end else begin
      reg_wrt_en_wb <= 1'b0;
      misalign_wb   <= 1'b0;
    end
  end

  // Galois LFSR, right-shifting; a zero state is stuck, so it is reloaded with the seed.
  always_ff @(posedge clk) begin
    if (!rst_n)             lfsr <= LFSR_SEED;
    else if (lfsr == '0)    lfsr <= LFSR_SEED;
    else if (lfsr[0])       lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
    else                    lfsr <= lfsr >> 1;
  end

endmodule
